// File: rtl/tm_program_driver.sv
// Initiator for the Turing-machine program/step handshake: streams a ROM script
// into the machine over Next/Done, then single-steps it to compute-done or a step limit.
module tm_program_driver #(
  parameter int DW      = 4,
  parameter int RAW     = 7,
  parameter int TIMEOUT = 255,
  parameter int SCW     = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [SCW-1:0] step_limit,
  output logic [RAW-1:0] rom_addr,
  input  logic [DW-1:0]  rom_data,
  input  logic [3:0]     tm_state,
  input  logic           tm_compute_done,
  output logic [DW-1:0]  tm_data,
  output logic           tm_next,
  output logic           tm_done,
  output logic           busy,
  output logic           loaded,
  output logic           halted,
  output logic           error,
  output logic [SCW-1:0] step_count
);

  localparam logic [3:0] ST_START       = 4'd0;
  localparam logic [3:0] ST_STATE_NUM   = 4'd1;
  localparam logic [3:0] ST_WAIT1       = 4'd2;
  localparam logic [3:0] ST_WRITE_STATE = 4'd3;
  localparam logic [3:0] ST_TAPE_ADDR   = 4'd4;
  localparam logic [3:0] ST_FILL_TAPE1  = 4'd5;
  localparam logic [3:0] ST_WAIT2       = 4'd6;
  localparam logic [3:0] ST_WRITE_TAPE  = 4'd7;
  localparam logic [3:0] ST_FILL_TAPE2  = 4'd8;
  localparam logic [3:0] ST_READ_DATA   = 4'd10;
  localparam logic [3:0] ST_READ_DIR    = 4'd12;
  localparam logic [3:0] ST_STOP        = 4'd14;

  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshake contract: a raised strobe (tm_next or tm_done) holds until tm_state
  // reports the acknowledge code, drops on the following cycle, and tm_data is
  // settled one full cycle before the strobe rises and held until it falls.
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_SETUP, S_RAISE, S_DROP, S_RUN, S_FINISHED, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    P_N, P_TRANS, P_DONE1, P_TADDR, P_K, P_TAPE, P_DONE2, P_RUN
  } phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [RAW-1:0] addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic [RAW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [SCW-1:0] steps_q, steps_d;
  logic           loaded_q, loaded_d;
  logic [RAW-1:0] n_ext;
  logic           done_phase;

  // Acknowledge code awaited while the strobe is high.
  function automatic logic match_raise(input phase_t p, input logic [3:0] s);
    case (p)
      P_N:     return s == ST_STATE_NUM;
      P_TRANS: return s == ST_WRITE_STATE;
      P_DONE1: return s == ST_TAPE_ADDR;
      P_TADDR: return (s == ST_FILL_TAPE1) || (s == ST_WAIT2);
      P_TAPE:  return s == ST_WRITE_TAPE;
      P_DONE2: return s >= ST_FILL_TAPE2;
      P_RUN:   return s == ST_READ_DIR;
      default: return 1'b0;
    endcase
  endfunction

  // Code awaited after the strobe drops, before the next transfer may begin.
  function automatic logic match_drop(input phase_t p, input logic [3:0] s);
    case (p)
      P_N, P_TRANS:  return s == ST_WAIT1;
      P_DONE1:       return s == ST_TAPE_ADDR;
      P_TADDR, P_TAPE: return s == ST_WAIT2;
      P_DONE2:       return s == ST_READ_DATA;
      P_RUN:         return (s == ST_READ_DATA) || (s == ST_STOP);
      default:       return 1'b0;
    endcase
  endfunction

  assign n_ext      = RAW'(rom_data);
  assign done_phase = (phase_q == P_DONE1) || (phase_q == P_DONE2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= P_N;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      steps_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      steps_q  <= steps_d;
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    steps_d  = steps_q;
    loaded_d = loaded_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (tm_state != ST_START) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_FETCH;
            phase_d = P_N;
            addr_d  = '0;
            steps_d = '0;
          end
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        addr_d = addr_q + RAW'(1);
        if (phase_q == P_K) begin
          // K sizes the tape loop only; it is never presented to the machine.
          cnt_d = RAW'(rom_data);
          if (rom_data == '0) begin
            phase_d = P_DONE2;
            state_d = S_RAISE;
            tmo_d   = '0;
          end else begin
            phase_d = P_TAPE;
            state_d = S_FETCH;
          end
        end else begin
          data_d  = rom_data;
          state_d = S_SETUP;
          if (phase_q == P_N) cnt_d = (n_ext << 2) + (n_ext << 1);
        end
      end
      S_SETUP: begin
        state_d = S_RAISE;
        tmo_d   = '0;
      end
      S_RAISE: begin
        if (match_raise(phase_q, tm_state)) begin
          state_d = S_DROP;
          tmo_d   = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DROP: begin
        if (match_drop(phase_q, tm_state)) begin
          tmo_d = '0;
          case (phase_q)
            P_N: begin
              if (cnt_q == '0) begin
                phase_d = P_DONE1;
                state_d = S_RAISE;
              end else begin
                phase_d = P_TRANS;
                state_d = S_FETCH;
              end
            end
            P_TRANS: begin
              cnt_d = cnt_q - RAW'(1);
              if (cnt_q == RAW'(1)) begin
                phase_d = P_DONE1;
                state_d = S_RAISE;
              end else begin
                state_d = S_FETCH;
              end
            end
            P_DONE1: begin
              phase_d = P_TADDR;
              state_d = S_FETCH;
            end
            P_TADDR: begin
              phase_d = P_K;
              state_d = S_FETCH;
            end
            P_TAPE: begin
              cnt_d = cnt_q - RAW'(1);
              if (cnt_q == RAW'(1)) begin
                phase_d = P_DONE2;
                state_d = S_RAISE;
              end else begin
                state_d = S_FETCH;
              end
            end
            P_DONE2: begin
              loaded_d = 1'b1;
              phase_d  = P_RUN;
              state_d  = S_RUN;
            end
            P_RUN: begin
              if (steps_q != '1) steps_d = steps_q + SCW'(1);
              state_d = S_RUN;
            end
            default: state_d = S_ERROR;
          endcase
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RUN: begin
        if (tm_compute_done || (tm_state == ST_STOP)) begin
          state_d = S_FINISHED;
        end else if ((step_limit != '0) && (steps_q == step_limit)) begin
          state_d = S_FINISHED;
        end else if (tm_state == ST_READ_DATA) begin
          state_d = S_RAISE;
          tmo_d   = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_FINISHED: state_d = S_FINISHED;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
  end

  // Strobes decode straight from registered state so reset clears them at once.
  assign tm_next    = (state_q == S_RAISE) && !done_phase;
  assign tm_done    = (state_q == S_RAISE) && done_phase;
  assign tm_data    = data_q;
  assign rom_addr   = addr_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_FINISHED) && (state_q != S_ERROR);
  assign loaded     = loaded_q;
  assign halted     = (state_q == S_FINISHED);
  assign error      = (state_q == S_ERROR);
  assign step_count = steps_q;

endmodule

// File: tb/tb_tm_program_driver.sv
// Bench for tm_program_driver: a reactive machine model, a sync ROM, and a
// scoreboard of script words expected on each load-phase Next rise.
module tb_tm_program_driver;
  localparam int DW  = 4;
  localparam int RAW = 7;
  localparam int SCW = 8;

  logic           clock;
  logic           reset;
  logic           start;
  logic [SCW-1:0] step_limit;
  logic [RAW-1:0] rom_addr;
  logic [DW-1:0]  rom_data;
  logic [3:0]     tm_state;
  logic           tm_compute_done;
  logic [DW-1:0]  tm_data;
  logic           tm_next;
  logic           tm_done;
  logic           busy;
  logic           loaded;
  logic           halted;
  logic           error;
  logic [SCW-1:0] step_count;

  tm_program_driver #(.DW(DW), .RAW(RAW), .TIMEOUT(255), .SCW(SCW)) dut (
    .clock(clock), .reset(reset), .start(start), .step_limit(step_limit),
    .rom_addr(rom_addr), .rom_data(rom_data), .tm_state(tm_state),
    .tm_compute_done(tm_compute_done), .tm_data(tm_data), .tm_next(tm_next),
    .tm_done(tm_done), .busy(busy), .loaded(loaded), .halted(halted),
    .error(error), .step_count(step_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] rom [0:127];
  always @(posedge clock) rom_data <= rom[rom_addr];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  int load_next, run_pulses, done_pulses, m_steps;
  int cd_step;
  logic stall, freeze;
  logic [3:0] init_code;
  logic prev_next, prev_done;
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Machine model plus per-cycle scoreboard; called once per falling edge.
  task automatic mon();
    logic [DW-1:0] e;
    if (reset) begin
      tm_state = init_code;
      m_steps = 0;
      tm_compute_done = 1'b0;
      prev_next = 1'b0;
      prev_done = 1'b0;
      prev_data = tm_data;
      return;
    end
    check("next_done_overlap", {31'd0, tm_next && tm_done}, 0);
    if (tm_data != prev_data) check("data_moved_under_strobe", {31'd0, prev_next || prev_done || tm_next || tm_done}, 0);
    if (tm_state < 4'd8) check("loaded_early", {31'd0, loaded}, 0);
    if (tm_next && !prev_next) begin
      if (tm_state == 4'd10) begin
        run_pulses++;
      end else begin
        load_next++;
        check("next_expected", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("next_data", {28'd0, tm_data}, {28'd0, e});
        end
      end
    end
    if (tm_done && !prev_done) done_pulses++;
    prev_next = tm_next;
    prev_done = tm_done;
    prev_data = tm_data;
    if (!freeze) begin
      case (tm_state)
        4'd0:  if (tm_next) tm_state = 4'd1;
        4'd1:  if (!tm_next) tm_state = 4'd2;
        4'd2:  if (tm_next) tm_state = 4'd3; else if (tm_done) tm_state = 4'd4;
        4'd3:  if (!tm_next && !stall) tm_state = 4'd2;
        4'd4:  if (tm_next) tm_state = 4'd5;
        4'd5:  if (!tm_next) tm_state = 4'd6;
        4'd6:  if (tm_next) tm_state = 4'd7; else if (tm_done) tm_state = 4'd8;
        4'd7:  if (!tm_next) tm_state = 4'd6;
        4'd8:  if (!tm_done) tm_state = 4'd9;
        4'd9:  tm_state = 4'd10;
        4'd10: if (tm_next) tm_state = 4'd11;
        4'd11: tm_state = 4'd12;
        4'd12: if (!tm_next) tm_state = 4'd13;
        4'd13: begin
          m_steps++;
          if (cd_step != 0 && m_steps == cd_step) tm_compute_done = 1'b1;
          tm_state = 4'd10;
        end
        default: ;
      endcase
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(negedge clock);
    mon();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic load_script(input int n, input int taddr, input int k);
    int six;
    for (int a = 0; a < 128; a++) rom[a] = '0;
    exp_q.delete();
    six = 6 * n;
    rom[0] = DW'(n);
    exp_q.push_back(DW'(n));
    for (int i = 1; i <= six; i++) begin
      rom[i] = DW'(((i - 1) % 15) + 1);
      exp_q.push_back(DW'(((i - 1) % 15) + 1));
    end
    rom[six + 1] = DW'(taddr);
    exp_q.push_back(DW'(taddr));
    rom[six + 2] = DW'(k);
    for (int j = 0; j < k; j++) begin
      rom[six + 3 + j] = DW'((j + 1) % 2);
      exp_q.push_back(DW'((j + 1) % 2));
    end
    load_next = 0;
    run_pulses = 0;
    done_pulses = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int i;
    for (i = 0; i < 3000 && !(halted || error); i++) cycle();
    check({name, "_ended"}, {31'd0, halted || error}, 1);
  endtask

  task automatic wait_loaded(input string name);
    int i;
    for (i = 0; i < 3000 && tm_state != 4'd10; i++) cycle();
    cycle();
    check({name, "_loaded"}, {31'd0, loaded}, 1);
  endtask

  initial begin
    int cnt;
    logic pn;
    reset = 1'b1; start = 1'b0; step_limit = '0;
    cd_step = 0; stall = 1'b0; freeze = 1'b0; init_code = 4'd0;
    tm_state = 4'd0; tm_compute_done = 1'b0;
    prev_next = 1'b0; prev_done = 1'b0; prev_data = '0;
    load_next = 0; run_pulses = 0; done_pulses = 0; m_steps = 0;
    for (int a = 0; a < 128; a++) rom[a] = '0;

    // Reset state
    do_reset();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_loaded", {31'd0, loaded}, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_next_done", {30'd0, tm_next, tm_done}, 0);
    check("rst_addr", {25'd0, rom_addr}, 0);
    check("rst_steps", {24'd0, step_count}, 0);

    // A: N=1, trans 1..6, taddr 10, K=2, tape {1,0}, limit 3
    load_script(1, 10, 2);
    step_limit = 8'd3;
    pulse_start();
    cycle();
    check("a_busy", {31'd0, busy}, 1);
    wait_loaded("a");
    check("a_load_next", load_next, 10);
    check("a_done_pulses", done_pulses, 2);
    check("a_exp_left", exp_q.size(), 0);
    wait_end("a");
    check("a_halted", {31'd0, halted}, 1);
    check("a_busy_end", {31'd0, busy}, 0);
    check("a_error", {31'd0, error}, 0);
    check("a_steps", {24'd0, step_count}, 3);
    check("a_run_pulses", run_pulses, 3);
    pulse_start();
    repeat (5) cycle();
    check("a_start_ignored", run_pulses + load_next, 13);

    // B: compute-done after step 2, unlimited
    do_reset();
    load_script(1, 10, 2);
    step_limit = 8'd0;
    cd_step = 2;
    pulse_start();
    wait_end("b");
    check("b_halted", {31'd0, halted}, 1);
    check("b_steps", {24'd0, step_count}, 2);
    check("b_run_pulses", run_pulses, 2);

    // F: N=2, K=0 skips the tape loop
    do_reset();
    load_script(2, 3, 0);
    step_limit = 8'd0;
    cd_step = 1;
    pulse_start();
    wait_loaded("f");
    check("f_load_next", load_next, 14);
    check("f_done_pulses", done_pulses, 2);
    wait_end("f");
    check("f_steps", {24'd0, step_count}, 1);
    check("f_halted", {31'd0, halted}, 1);

    // C: machine stalls in WRITE_STATE
    cd_step = 0;
    stall = 1'b1;
    do_reset();
    load_script(1, 10, 2);
    step_limit = 8'd0;
    pulse_start();
    pn = tm_next;
    for (int i = 0; i < 500; i++) begin
      cycle();
      if (pn && !tm_next && tm_state == 4'd3) break;
      pn = tm_next;
    end
    cnt = 0;
    while (!error && cnt < 400) begin
      cycle();
      cnt++;
    end
    check("c_timeout_cycles", cnt, 255);
    check("c_error", {31'd0, error}, 1);
    check("c_next_low", {31'd0, tm_next}, 0);
    check("c_busy", {31'd0, busy}, 0);
    pulse_start();
    repeat (5) cycle();
    check("c_error_sticky", {31'd0, error}, 1);
    stall = 1'b0;

    // D: start while the machine is not at START
    init_code = 4'd5;
    freeze = 1'b1;
    do_reset();
    load_script(1, 10, 2);
    pulse_start();
    cycle();
    check("d_error", {31'd0, error}, 1);
    check("d_busy", {31'd0, busy}, 0);
    repeat (10) cycle();
    check("d_no_next", load_next + run_pulses, 0);
    freeze = 1'b0;
    init_code = 4'd0;

    // E: reset mid-transition-transfer with Next high, then restart
    do_reset();
    load_script(2, 3, 1);
    step_limit = 8'd2;
    for (int i = 0; i < 500 && !(tm_next && tm_state == 4'd3); i++) cycle();
    pulse_start();
    for (int i = 0; i < 500 && !(tm_next && tm_state == 4'd3); i++) cycle();
    check("e_next_high_before", {31'd0, tm_next}, 1);
    #2 reset = 1'b1;
    #1 check("e_async_next_drop", {31'd0, tm_next}, 0);
    check("e_async_addr", {25'd0, rom_addr}, 0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    load_script(2, 3, 1);
    pulse_start();
    for (int i = 0; i < 100 && !tm_next; i++) cycle();
    check("e_restart_word0", {28'd0, tm_data}, 2);
    wait_end("e");
    check("e_steps", {24'd0, step_count}, 2);
    check("e_load_next", load_next, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
